// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one external FP adder (latency LAT) between NREQ
// requesters; tags each issued operation and routes the sum back to its owner.
module fpadd_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 0,
  parameter int TW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               add_valid,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  input  logic [31:0]        add_sum,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_sum,
  output logic [NREQ-1:0]    busy,
  output logic               idle
);

  logic [TW-1:0]   ptr;
  logic [TW-1:0]   grant_idx;
  logic            grant_any;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant_oh;
  logic [TW-1:0]   iss_tag;
  logic            out_valid;
  logic [TW-1:0]   out_tag;
  logic [NREQ-1:0] ret_oh;
  logic [31:0]     op_a [NREQ];
  logic [31:0]     op_b [NREQ];

  // Index arithmetic modulo NREQ; base is always < NREQ so one subtraction suffices.
  function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s -= NREQ;
    return TW'(s);
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = req_a[32*i +: 32];
    assign op_b[i] = req_b[32*i +: 32];
  end

  assign elig = req_valid & ~busy;

  // Scan from the farthest offset back to ptr so the nearest eligible index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[wrap_add(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = grant_oh;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= wrap_add(grant_idx, 1);
    end
  end

  // NOTE: operand/sum data registers are reset too, so outputs are deterministic after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_valid <= 1'b0;
      iss_tag   <= '0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      add_valid <= grant_any;
      if (grant_any) begin
        iss_tag <= grant_idx;
        add_a   <= op_a[grant_idx];
        add_b   <= op_b[grant_idx];
      end
    end
  end

  if (LAT == 0) begin : g_tag_direct
    assign out_valid = add_valid;
    assign out_tag   = iss_tag;
  end else begin : g_tag_pipe
    logic          pv [LAT];
    logic [TW-1:0] pt [LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < LAT; k++) begin
          pv[k] <= 1'b0;
          pt[k] <= '0;
        end
      end else begin
        pv[0] <= add_valid;
        pt[0] <= iss_tag;
        for (int k = 1; k < LAT; k++) begin
          pv[k] <= pv[k-1];
          pt[k] <= pt[k-1];
        end
      end
    end

    assign out_valid = pv[LAT-1];
    assign out_tag   = pt[LAT-1];
  end

  always_comb begin
    ret_oh = '0;
    if (out_valid) ret_oh[out_tag] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
    end else begin
      rsp_valid <= ret_oh;
      if (out_valid) rsp_sum <= add_sum;
    end
  end

  // A busy requester is never granted, so set and clear cannot hit the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy | grant_oh) & ~ret_oh;
    end
  end

  assign idle = ~|busy;

endmodule
